// File: rtl/int_controller.sv
// Prioritised, maskable interrupt controller in front of the uc `interrupcion` input.
// It latches rising edges on the irq lines as pending requests. It grants the
// lowest-index enabled line with a registered one-cycle pulse and the matching
// ISR vector. It then tracks the line in service until the uc signals `retorno`.
// Optional build macro: NESTED_INT_EN. When defined, a strictly higher-priority
// request preempts the line in service, and return clears service bits one
// nesting level at a time.
module int_controller #(
    parameter int unsigned          N_IRQ       = 4,
    parameter int unsigned          VEC_WIDTH   = 10,
    parameter logic [VEC_WIDTH-1:0] BASE_VECTOR = 10'h3F0,
    parameter int unsigned          VEC_STRIDE  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq,
    input  logic                 retorno,
    input  logic                 we_mask,
    input  logic [N_IRQ-1:0]     mask_in,
    output logic                 interrupcion,
    output logic [VEC_WIDTH-1:0] vector,
    output logic [N_IRQ-1:0]     pending,
    output logic [N_IRQ-1:0]     in_service,
    output logic                 busy
);

    localparam int unsigned IdW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e                 state_q, state_d;
    logic [N_IRQ-1:0]       irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0]       pending_q, pending_d;
    logic [N_IRQ-1:0]       in_service_q, in_service_d;
    logic [N_IRQ-1:0]       mask_q, mask_d;
    logic                   interrupcion_q, interrupcion_d;
    logic [VEC_WIDTH-1:0]   vector_q, vector_d;

    logic [N_IRQ-1:0]       edge_v;
    logic [N_IRQ-1:0]       eligible;
    logic                   win_vld;
    logic [IdW-1:0]         win_id;
    logic [N_IRQ-1:0]       win_oh;
    logic [IdW-1:0]         hi_svc;
    logic [N_IRQ-1:0]       hi_oh;
    logic                   grant;
    logic [N_IRQ-1:0]       svc_clr;

    // Edge detection plus priority pick of the winner and the innermost in-service line
    always_comb begin
        edge_v   = irq & ~irq_prev_q;
        eligible = pending_q & mask_q;
        win_vld  = |eligible;
        win_id   = '0;
        hi_svc   = '0;
        // Scan downwards so the lowest set index is the one left standing
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = IdW'(i);
            end
            if (in_service_q[i]) begin
                hi_svc = IdW'(i);
            end
        end
        win_oh = N_IRQ'(1) << win_id;
        hi_oh  = N_IRQ'(1) << hi_svc;
    end

    // FSM next state, pending/in-service bookkeeping and registered grant outputs
    always_comb begin
        state_d    = state_q;
        irq_prev_d = irq;
        mask_d     = we_mask ? mask_in : mask_q;
        grant      = 1'b0;
        svc_clr    = '0;

        unique case (state_q)
            StIdle: begin
                grant = win_vld;
            end
            StReq: begin
                state_d = StService;
            end
            StService: begin
                // A return wins over any grant in the same cycle; the grant follows later
                if (retorno) begin
                    svc_clr = hi_oh;
`ifdef NESTED_INT_EN
                    if ((in_service_q & ~hi_oh) == '0) begin
                        state_d = StIdle;
                    end
                end else if (win_vld && (win_id < hi_svc)) begin
                    grant = 1'b1;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (grant) begin
            state_d = StReq;
        end

        // A fresh edge on the line being granted re-arms it: set beats clear
        pending_d      = (pending_q & ~(grant ? win_oh : '0)) | edge_v;
        in_service_d   = (in_service_q & ~svc_clr) | (grant ? win_oh : '0);
        interrupcion_d = grant;
        vector_d       = grant ? (BASE_VECTOR + VEC_WIDTH'(win_id) * VEC_WIDTH'(VEC_STRIDE))
                               : '0;
    end

    // All controller state, reset asynchronously to idle with every line disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            irq_prev_q     <= '0;
            pending_q      <= '0;
            in_service_q   <= '0;
            mask_q         <= '0;
            interrupcion_q <= 1'b0;
            vector_q       <= '0;
        end else begin
            state_q        <= state_d;
            irq_prev_q     <= irq_prev_d;
            pending_q      <= pending_d;
            in_service_q   <= in_service_d;
            mask_q         <= mask_d;
            interrupcion_q <= interrupcion_d;
            vector_q       <= vector_d;
        end
    end

    assign interrupcion = interrupcion_q;
    assign vector       = vector_q;
    assign pending      = pending_q;
    assign in_service   = in_service_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with default parameters; follows NESTED_INT_EN if defined.
module tb_int_controller;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       retorno;
    logic       we_mask;
    logic [3:0] mask_in;
    logic       interrupcion;
    logic [9:0] vector;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int count;

    int_controller dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .retorno      (retorno),
        .we_mask      (we_mask),
        .mask_in      (mask_in),
        .interrupcion (interrupcion),
        .vector       (vector),
        .pending      (pending),
        .in_service   (in_service),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic i_exp, input logic [9:0] v_exp,
                           input logic [3:0] p_exp, input logic [3:0] s_exp, input logic b_exp);
        chk({tag, ".int"}, 32'(interrupcion), 32'(i_exp));
        chk({tag, ".vec"}, 32'(vector), 32'(v_exp));
        chk({tag, ".pend"}, 32'(pending), 32'(p_exp));
        chk({tag, ".insvc"}, 32'(in_service), 32'(s_exp));
        chk({tag, ".busy"}, 32'(busy), 32'(b_exp));
    endtask

    initial begin
        reset   = 1'b1;
        irq     = '0;
        retorno = 1'b0;
        we_mask = 1'b0;
        mask_in = '0;
        tick();
        tick();
        chk_all("reset", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);
        reset = 1'b0;
        tick();

        // 1: single request on line 2
        we_mask = 1'b1; mask_in = 4'hF;
        tick();
        we_mask = 1'b0; irq = 4'b0100;
        tick();
        chk_all("t1.pend", 1'b0, 10'h0, 4'b0100, 4'h0, 1'b0);
        irq = '0;
        tick();
        chk_all("t1.req", 1'b1, 10'h3F8, 4'h0, 4'b0100, 1'b1);
        tick();
        chk_all("t1.svc", 1'b0, 10'h0, 4'h0, 4'b0100, 1'b1);
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t1.ret", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);

        // 2: simultaneous lines 3 and 1
        irq = 4'b1010;
        tick();
        irq = '0;
        tick();
        chk_all("t2.req1", 1'b1, 10'h3F4, 4'b1000, 4'b0010, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t2.ret1", 1'b0, 10'h0, 4'b1000, 4'h0, 1'b0);
        tick();
        chk_all("t2.req3", 1'b1, 10'h3FC, 4'h0, 4'b1000, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t2.ret3", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);

        // 3: masked line 0 stays pending until enabled
        we_mask = 1'b1; mask_in = 4'b1110;
        tick();
        we_mask = 1'b0; irq = 4'b0001;
        tick();
        irq = '0;
        tick();
        tick();
        chk_all("t3.masked", 1'b0, 10'h0, 4'b0001, 4'h0, 1'b0);
        we_mask = 1'b1; mask_in = 4'hF;
        tick();
        we_mask = 1'b0;
        chk_all("t3.wr", 1'b0, 10'h0, 4'b0001, 4'h0, 1'b0);
        tick();
        chk_all("t3.req", 1'b1, 10'h3F0, 4'h0, 4'b0001, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;

        // 4: line 0 arrives while line 2 is in service
        irq = 4'b0100;
        tick();
        irq = '0;
        tick();
        tick();
        irq = 4'b0001;
        tick();
        irq = '0;
        tick();
`ifdef NESTED_INT_EN
        chk_all("t4.nest", 1'b1, 10'h3F0, 4'h0, 4'b0101, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        chk_all("t4.ret1", 1'b0, 10'h0, 4'h0, 4'b0100, 1'b1);
        tick();
        retorno = 1'b0;
        chk_all("t4.ret2", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);
`else
        chk_all("t4.hold", 1'b0, 10'h0, 4'b0001, 4'b0100, 1'b1);
        tick();
        chk_all("t4.hold2", 1'b0, 10'h0, 4'b0001, 4'b0100, 1'b1);
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t4.ret", 1'b0, 10'h0, 4'b0001, 4'h0, 1'b0);
        tick();
        chk_all("t4.req0", 1'b1, 10'h3F0, 4'h0, 4'b0001, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t4.end", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);
`endif

        // 5: held level gives one request; reset mid-service clears everything at once
        irq = 4'b0010;
        tick();
        count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            count += int'(interrupcion);
        end
        chk("t5.one_int", 32'(count), 32'd1);
        chk("t5.insvc", 32'(in_service), 32'b0010);
        #2;
        reset = 1'b1;
        irq   = '0;
        #1;
        chk_all("t5.rst", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);
        tick();
        reset = 1'b0;
        count = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            count += int'(interrupcion);
        end
        chk("t5.no_int", 32'(count), 32'd0);
        chk("t5.idle", 32'(busy), 32'd0);

        // 6: stray return in idle, then re-arm on the grant cycle
        we_mask = 1'b1; mask_in = 4'hF;
        tick();
        we_mask = 1'b0; retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t6.stray", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);
        we_mask = 1'b1; mask_in = 4'b1101; irq = 4'b0010;
        tick();
        we_mask = 1'b0; irq = '0;
        tick();
        chk_all("t6.masked", 1'b0, 10'h0, 4'b0010, 4'h0, 1'b0);
        we_mask = 1'b1; mask_in = 4'hF;
        tick();
        we_mask = 1'b0; irq = 4'b0010;
        tick();
        irq = '0;
        chk_all("t6.rearm", 1'b1, 10'h3F4, 4'b0010, 4'b0010, 1'b1);
        tick();
        chk_all("t6.svc", 1'b0, 10'h0, 4'b0010, 4'b0010, 1'b1);
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t6.ret", 1'b0, 10'h0, 4'b0010, 4'h0, 1'b0);
        tick();
        chk_all("t6.regrant", 1'b1, 10'h3F4, 4'h0, 4'b0010, 1'b1);
        tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        chk_all("t6.end", 1'b0, 10'h0, 4'h0, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
